gain_ramp_ctrl: RTL and testbench
=================================

Name: gain_ramp_ctrl

Overview:
- Sequences all writes into the equalizer register map (config byte at address 0; ten 24-bit band gains at addresses 1..30, LSB first).
- The host supplies per-band target gains. On each ramp_tick, the block moves every band's live gain toward its target by at most RAMP_STEP. It then writes the changed bytes through the register map's byte write port.
- Purpose: avoids zipper noise from abrupt gain jumps.
- Sits between the host/control logic and reg_map, and is the sole driver of the map's we/addr/data_in.

Parameters:
- GAIN_WIDTH, 24, gain word width; fixed at 3 bytes.
- NUM_BANDS, 10, number of equalizer bands.
- RAMP_STEP, 24'h080000, maximum per-tick change of one band gain.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ramp_tick  in  1  one-cycle pulse; starts one ramp pass
- tgt_valid  in  1  target write strobe
- tgt_band  in  4  band index, 1..10
- tgt_gain  in  24  target gain, unsigned
- tgt_err  out  1  sticky: tgt_valid seen with band 0 or >10
- cfg_valid  in  1  config write request
- cfg_data  in  8  configuration byte
- cfg_ready  out  1  config request accepted this cycle
- reg_we  out  1  write enable to reg_map
- reg_addr  out  8  byte address to reg_map
- reg_data  out  8  byte data to reg_map
- busy  out  1  high while not IDLE
- ramp_done  out  1  one-cycle pulse at end of a pass
- overrun  out  1  sticky: ramp_tick dropped

Behaviour:
- Reset (async, rst=0):
  - All current and target gains = 0; state = IDLE.
  - reg_we = 0, reg_addr = 0, reg_data = 0; busy = 0; ramp_done = 0; overrun = 0; tgt_err = 0; pending = 0.
  - Reset asserted mid-write drops reg_we immediately and discards the remaining writes.
- Targets:
  - Accepted on any cycle where tgt_valid = 1.
  - A valid band overwrites target[band]; it takes effect when that band is next scanned.
  - An invalid band is ignored and sets tgt_err.
- Ticks:
  - A ramp_tick while busy sets pending.
  - A ramp_tick while pending is already set is dropped and sets overrun.
  - ramp_tick in IDLE, or pending, starts a pass.
- FSM states: IDLE, CFG_WR, SCAN, WR0, WR1, WR2.
  - IDLE: cfg_valid has priority over a tick or pending.
    - On cfg_valid: cfg_ready = 1 (combinational, IDLE only), go to CFG_WR.
    - Otherwise, on tick or pending: clear pending, band = 1, go to SCAN.
  - CFG_WR (1 cycle): reg_we = 1, reg_addr = 0, reg_data = cfg_data (latched at acceptance); then IDLE.
  - SCAN (1 cycle per band): compute next = step(current, target).
    - If next != current: current <= next, go to WR0.
    - Otherwise advance the band. After band 10, go to IDLE and pulse ramp_done.
  - WR0 / WR1 / WR2: reg_we = 1, reg_addr = 3b-2 / 3b-1 / 3b, reg_data = current[7:0] / [15:8] / [23:16].
    - After WR2: next band's SCAN, or IDLE with ramp_done after band 10.
- step():
  - Unsigned arithmetic.
  - If target > current: current + min(RAMP_STEP, target - current).
  - If target < current: current - min(RAMP_STEP, current - target).
  - Never overshoots; no wrap.
- Outputs reg_we/addr/data are registered and valid during the WR/CFG_WR cycles. reg_map captures on the closing edge.
- Latency: ramp_done is high in the cycle following edge 10 + 3N after the tick is accepted, where N = number of changed bands.
- A pending tick starts a new pass directly from IDLE on the next cycle, unless cfg_valid is high.

Optional Feature:
- Macro: GAIN_RAMP_FULL_REFRESH_EN.
- Defined: SCAN always goes to WR0, so every pass writes all 30 gain bytes even when unchanged. Pass length = 40 cycles. Recovers reg_map after an external reset.
- Undefined: only changed bands are written, as above.

Test Plan:
- Reset, tick with all targets 0 -> no reg_we; ramp_done after 10 cycles; busy high for 10 cycles.
- Target band 2 = 0x1C71C7, five ticks:
  - Tick 1: write 0x080000 (addr4 = 00, addr5 = 00, addr6 = 08).
  - Ticks 2 and 3: writes of 0x100000, then 0x180000.
  - Tick 4: write 0x1C71C7 (C7, 71, 1C at addr 4, 5, 6).
  - Tick 5: no writes.
- Band 10 ramped to 0xFFFFFF, then target 0x000000 -> values decrease by 0x080000 per tick, ending at 0x000000 with no underflow.
- cfg_valid with 0xAA together with ramp_tick in IDLE -> single write addr0 = 0xAA first, then the pass starts the cycle after. Two more ticks during the pass -> one extra pass runs; overrun = 1.
- tgt_band = 11 -> tgt_err = 1, no target changes. Reset asserted during WR1 -> reg_we = 0 immediately; all outputs at reset values.
- With GAIN_RAMP_FULL_REFRESH_EN: tick with no changes -> 30 writes, addresses 1..30 in order; ramp_done after 40 cycles.

Source files
------------

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: sequences every write into the equalizer register map.
// Config byte goes to address 0. Band b (1..10) gain bytes go to 3b-2 / 3b-1 / 3b, LSB first.
// On each ramp pass, every band's live gain moves toward its target by at most RAMP_STEP.
// Only the bands that changed are written back.
// Optional build macro GAIN_RAMP_FULL_REFRESH_EN: every pass rewrites all 30 gain bytes,
// which restores reg_map contents after reg_map has been reset on its own.
module gain_ramp_ctrl #(
  parameter int                    GAIN_WIDTH = 24,
  parameter int                    NUM_BANDS  = 10,
  parameter logic [GAIN_WIDTH-1:0] RAMP_STEP  = 24'h080000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ramp_tick,
  input  logic                  tgt_valid,
  input  logic [3:0]            tgt_band,
  input  logic [GAIN_WIDTH-1:0] tgt_gain,
  output logic                  tgt_err,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_data,
  output logic                  cfg_ready,
  output logic                  reg_we,
  output logic [7:0]            reg_addr,
  output logic [7:0]            reg_data,
  output logic                  busy,
  output logic                  ramp_done,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG_WR = 3'd1,
    SCAN   = 3'd2,
    WR0    = 3'd3,
    WR1    = 3'd4,
    WR2    = 3'd5
  } state_t;

  localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS);

  state_t                  state_r, state_s;
  logic [3:0]              band_r;
  logic [3:0]              band_idx_s;
  logic                    last_band_s;
  logic                    pending_r;
  logic [GAIN_WIDTH-1:0]   cur_r [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]   tgt_r [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]   cur_sel_s;
  logic [GAIN_WIDTH-1:0]   step_s;
  logic                    changed_s;
  logic [7:0]              band3_s;
  logic                    we_s;
  logic [7:0]              addr_s;
  logic [7:0]              data_s;
  logic                    done_s;
  logic                    start_s;
  logic                    tgt_ok_s;

  // One ramp step toward the target, clamped so it never overshoots or wraps.
  function automatic logic [GAIN_WIDTH-1:0] step_gain(input logic [GAIN_WIDTH-1:0] cur,
                                                      input logic [GAIN_WIDTH-1:0] tgt);
    logic [GAIN_WIDTH-1:0] diff;
    diff = '0;
    if (tgt > cur) begin
      diff = tgt - cur;
      if (diff > RAMP_STEP) step_gain = cur + RAMP_STEP;
      else                  step_gain = tgt;
    end else if (tgt < cur) begin
      diff = cur - tgt;
      if (diff > RAMP_STEP) step_gain = cur - RAMP_STEP;
      else                  step_gain = tgt;
    end else begin
      step_gain = cur;
    end
  endfunction

  // band_r is held in 1..NUM_BANDS, so the array index is always in range.
  assign band_idx_s  = band_r - 4'd1;
  assign last_band_s = (band_r == LAST_BAND);
  assign cur_sel_s   = cur_r[band_idx_s];
  assign step_s      = step_gain(cur_sel_s, tgt_r[band_idx_s]);
  assign changed_s   = (step_s != cur_sel_s);
  assign band3_s     = ({4'd0, band_r} << 1) + {4'd0, band_r};
  assign start_s     = (state_r == IDLE) && (state_s == SCAN);
  assign tgt_ok_s    = (tgt_band != 4'd0) && (tgt_band <= LAST_BAND);
  assign busy        = (state_r != IDLE);
  assign cfg_ready   = cfg_valid && (state_r == IDLE);

  // Next-state logic; config writes take priority over starting a pass.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_valid)                   state_s = CFG_WR;
        else if (ramp_tick || pending_r) state_s = SCAN;
        else                             state_s = IDLE;
      end
      CFG_WR: state_s = IDLE;
      SCAN: begin
`ifdef GAIN_RAMP_FULL_REFRESH_EN
        state_s = WR0;
`else
        if (changed_s)        state_s = WR0;
        else if (last_band_s) state_s = IDLE;
        else                  state_s = SCAN;
`endif
      end
      WR0: state_s = WR1;
      WR1: state_s = WR2;
      WR2: begin
        if (last_band_s) state_s = IDLE;
        else             state_s = SCAN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Values for the registered write port, chosen from the state about to be entered.
  always_comb begin
    we_s   = 1'b0;
    addr_s = 8'd0;
    data_s = 8'd0;
    case (state_s)
      CFG_WR: begin we_s = 1'b1; addr_s = 8'd0;           data_s = cfg_data;         end
      WR0:    begin we_s = 1'b1; addr_s = band3_s - 8'd2; data_s = step_s[7:0];      end
      WR1:    begin we_s = 1'b1; addr_s = band3_s - 8'd1; data_s = cur_sel_s[15:8];  end
      WR2:    begin we_s = 1'b1; addr_s = band3_s;        data_s = cur_sel_s[23:16]; end
      default: begin we_s = 1'b0; addr_s = 8'd0; data_s = 8'd0; end
    endcase
    if (((state_r == SCAN) || (state_r == WR2)) && (state_s == IDLE)) done_s = 1'b1;
    else                                                              done_s = 1'b0;
  end

  // State, band pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      band_r    <= 4'd1;
      reg_we    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_data  <= 8'd0;
      ramp_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      reg_we    <= we_s;
      reg_addr  <= addr_s;
      reg_data  <= data_s;
      ramp_done <= done_s;
      if (start_s) begin
        band_r <= 4'd1;
      end else if (((state_r == SCAN) && (state_s != WR0)) || (state_r == WR2)) begin
        band_r <= last_band_s ? 4'd1 : band_r + 4'd1;
      end
    end
  end

  // Target capture, live gain update during SCAN, and the sticky bad-band flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        cur_r[i] <= '0;
        tgt_r[i] <= '0;
      end
      tgt_err <= 1'b0;
    end else begin
      if (tgt_valid) begin
        if (tgt_ok_s) tgt_r[tgt_band - 4'd1] <= tgt_gain;
        else          tgt_err <= 1'b1;
      end
      if (state_r == SCAN) cur_r[band_idx_s] <= step_s;
    end
  end

  // Tick bookkeeping: one tick may wait while busy, a further one is dropped and flagged.
  // A tick that arrives together with an already pending one at pass start stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ramp_tick && !start_s) begin
        if (pending_r) overrun   <= 1'b1;
        else           pending_r <= 1'b1;
      end else if (start_s) begin
        pending_r <= ramp_tick && pending_r;
      end
    end
  end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed self-checking bench for gain_ramp_ctrl.
module tb_gain_ramp_ctrl;

`ifdef GAIN_RAMP_FULL_REFRESH_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ramp_tick, tgt_valid, cfg_valid;
  logic [3:0]  tgt_band;
  logic [23:0] tgt_gain;
  logic [7:0]  cfg_data;
  logic        tgt_err, cfg_ready, reg_we, busy, ramp_done, overrun;
  logic [7:0]  reg_addr, reg_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wr_q [$];
  logic [7:0]  mem [0:30];
  int          done_cnt = 0;

  gain_ramp_ctrl dut (
    .clk(clk), .rst(rst), .ramp_tick(ramp_tick), .tgt_valid(tgt_valid),
    .tgt_band(tgt_band), .tgt_gain(tgt_gain), .tgt_err(tgt_err),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .busy(busy), .ramp_done(ramp_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behaves like reg_map: captures a byte on the edge that closes a write cycle.
  always @(posedge clk) begin
    if (reg_we === 1'b1) begin
      mem[reg_addr] <= reg_data;
      wr_q.push_back({reg_addr, reg_data});
    end
    if (ramp_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic int exp_lat(int nchg);
    return FULL ? 40 : 10 + 3 * nchg;
  endfunction

  function automatic int exp_wr(int nchg);
    return FULL ? 30 : 3 * nchg;
  endfunction

  function automatic logic [23:0] gain_of(int b);
    return {mem[3*b], mem[3*b-1], mem[3*b-2]};
  endfunction

  task automatic set_tgt(input logic [3:0] b, input logic [23:0] g);
    @(negedge clk); tgt_valid = 1'b1; tgt_band = b; tgt_gain = g;
    @(negedge clk); tgt_valid = 1'b0; tgt_band = 4'd0; tgt_gain = 24'd0;
  endtask

  // Pulses one tick, then counts cycles until ramp_done (bounded).
  task automatic do_pass(output int lat, output int bcyc);
    int n;
    n = 0; bcyc = 0;
    @(negedge clk); wr_q.delete(); ramp_tick = 1'b1;
    @(negedge clk); ramp_tick = 1'b0;
    while (ramp_done !== 1'b1 && n < 300) begin
      if (busy === 1'b1) bcyc++;
      n++;
      @(negedge clk);
    end
    lat = n;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({reg_we, reg_addr, reg_data, busy, ramp_done, overrun, tgt_err} !== 21'd0) begin
      n_bad++;
      $display("FAIL %s: got we=%b addr=%h data=%h busy=%b done=%b ovr=%b err=%b want all 0",
               tag, reg_we, reg_addr, reg_data, busy, ramp_done, overrun, tgt_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ramp_tick = 1'b0; tgt_valid = 1'b0; cfg_valid = 1'b0;
    tgt_band = 4'd0; tgt_gain = 24'd0; cfg_data = 8'd0;
    for (int i = 0; i <= 30; i++) mem[i] = 8'd0;
    #12;
    check_idle_outputs("reset_outputs");
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_zero_pass();
    int lat, bc;
    do_pass(lat, bc);
    n_cmp++; if (lat !== exp_lat(0)) begin n_bad++; $display("FAIL zero_lat: got %0d want %0d", lat, exp_lat(0)); end
    n_cmp++; if (bc !== exp_lat(0)) begin n_bad++; $display("FAIL zero_busy: got %0d want %0d", bc, exp_lat(0)); end
    n_cmp++; if (wr_q.size() !== exp_wr(0)) begin n_bad++; $display("FAIL zero_writes: got %0d want %0d", wr_q.size(), exp_wr(0)); end
    @(negedge clk);
    n_cmp++; if (ramp_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", ramp_done); end
  endtask

  task automatic test_ramp_up();
    int lat, bc;
    logic [23:0] exp [5];
    int          chg [5];
    exp = '{24'h080000, 24'h100000, 24'h180000, 24'h1C71C7, 24'h1C71C7};
    chg = '{1, 1, 1, 1, 0};
    set_tgt(4'd2, 24'h1C71C7);
    for (int t = 0; t < 5; t++) begin
      do_pass(lat, bc);
      n_cmp++; if (lat !== exp_lat(chg[t])) begin n_bad++; $display("FAIL up_lat[%0d]: got %0d want %0d", t, lat, exp_lat(chg[t])); end
      n_cmp++; if (wr_q.size() !== exp_wr(chg[t])) begin n_bad++; $display("FAIL up_writes[%0d]: got %0d want %0d", t, wr_q.size(), exp_wr(chg[t])); end
      n_cmp++; if (gain_of(2) !== exp[t]) begin n_bad++; $display("FAIL up_gain[%0d]: got %h want %h", t, gain_of(2), exp[t]); end
`ifndef GAIN_RAMP_FULL_REFRESH_EN
      if (t == 0) begin
        n_cmp++;
        if (wr_q.size() != 3 || wr_q[0] !== 16'h0400 || wr_q[1] !== 16'h0500 || wr_q[2] !== 16'h0608) begin
          n_bad++; $display("FAIL up_order: got %0d writes first=%h want 0400,0500,0608", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 16'hxxxx);
        end
      end
`endif
    end
  endtask

  task automatic test_ramp_down();
    int lat, bc;
    logic [23:0] e;
    set_tgt(4'd10, 24'hFFFFFF);
    for (int t = 0; t < 32; t++) do_pass(lat, bc);
    n_cmp++; if (gain_of(10) !== 24'hFFFFFF) begin n_bad++; $display("FAIL top_gain: got %h want ffffff", gain_of(10)); end
    set_tgt(4'd10, 24'h000000);
    e = 24'hFFFFFF;
    for (int t = 0; t < 32; t++) begin
      do_pass(lat, bc);
      e = (e > 24'h080000) ? e - 24'h080000 : 24'h000000;
      n_cmp++; if (gain_of(10) !== e) begin n_bad++; $display("FAIL down_gain[%0d]: got %h want %h", t, gain_of(10), e); end
    end
    do_pass(lat, bc);
    n_cmp++; if (lat !== exp_lat(0)) begin n_bad++; $display("FAIL floor_lat: got %0d want %0d", lat, exp_lat(0)); end
    n_cmp++; if (gain_of(10) !== 24'h000000) begin n_bad++; $display("FAIL floor_gain: got %h want 000000", gain_of(10)); end
  endtask

  task automatic test_cfg_and_overrun();
    int base, n;
    @(negedge clk);
    wr_q.delete(); base = done_cnt;
    cfg_valid = 1'b1; cfg_data = 8'hAA; ramp_tick = 1'b1;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready: got %b want 1", cfg_ready); end
    @(negedge clk); cfg_valid = 1'b0; cfg_data = 8'd0; ramp_tick = 1'b0;
    n_cmp++; if ({reg_we, reg_addr, reg_data, busy} !== {1'b1, 8'h00, 8'hAA, 1'b1}) begin
      n_bad++; $display("FAIL cfg_write: got we=%b addr=%h data=%h busy=%b want 1 00 aa 1", reg_we, reg_addr, reg_data, busy);
    end
    @(negedge clk);
    n_cmp++; if (wr_q.size() != 1 || wr_q[0] !== 16'h00AA || busy !== 1'b0) begin
      n_bad++; $display("FAIL cfg_only: got %0d writes busy=%b want 1 write 00aa busy 0", wr_q.size(), busy);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pend_start: got busy=%b want 1", busy); end
    ramp_tick = 1'b1; @(negedge clk); ramp_tick = 1'b0;
    @(negedge clk); ramp_tick = 1'b1; @(negedge clk); ramp_tick = 1'b0;
    n = 0;
    while (done_cnt - base < 2 && n < 300) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    n_cmp++; if (done_cnt - base !== 2) begin n_bad++; $display("FAIL pass_count: got %0d want 2", done_cnt - base); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun: got %b want 1", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL settle_busy: got %b want 0", busy); end
  endtask

  task automatic test_tgt_err();
    int lat, bc;
    n_cmp++; if (tgt_err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b want 0", tgt_err); end
    set_tgt(4'd11, 24'h123456);
    n_cmp++; if (tgt_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", tgt_err); end
    do_pass(lat, bc);
    n_cmp++; if (wr_q.size() !== exp_wr(0)) begin n_bad++; $display("FAIL err_nochg: got %0d writes want %0d", wr_q.size(), exp_wr(0)); end
  endtask

  task automatic test_reset_mid_write();
    int n, lat, bc;
    set_tgt(4'd1, 24'h000010);
    @(negedge clk); ramp_tick = 1'b1;
    @(negedge clk); ramp_tick = 1'b0;
    n = 0;
    while (!(reg_we === 1'b1 && reg_addr === 8'd2) && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 100) begin n_bad++; $display("FAIL wr1_wait: got timeout after %0d cycles want WR1", n); end
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_write");
    @(negedge clk); rst = 1'b1;
    do_pass(lat, bc);
    n_cmp++; if (lat !== exp_lat(0)) begin n_bad++; $display("FAIL post_rst_lat: got %0d want %0d", lat, exp_lat(0)); end
    n_cmp++; if (wr_q.size() !== exp_wr(0)) begin n_bad++; $display("FAIL post_rst_writes: got %0d want %0d", wr_q.size(), exp_wr(0)); end
  endtask

`ifdef GAIN_RAMP_FULL_REFRESH_EN
  task automatic test_full_refresh();
    int lat, bc, bad_order;
    do_pass(lat, bc);
    n_cmp++; if (lat !== 40) begin n_bad++; $display("FAIL full_lat: got %0d want 40", lat); end
    bad_order = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i][15:8] !== 8'(i + 1)) bad_order++;
    n_cmp++; if (wr_q.size() != 30 || bad_order != 0) begin
      n_bad++; $display("FAIL full_order: got %0d writes %0d misplaced want 30 in order", wr_q.size(), bad_order);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_pass();
    test_ramp_up();
    test_ramp_down();
    test_cfg_and_overrun();
    test_tgt_err();
    test_reset_mid_write();
`ifdef GAIN_RAMP_FULL_REFRESH_EN
    test_full_refresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
